// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/mem/writeback control FSM for the RV32 core
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             writes_rd,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic             rf_we,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic [2:0]       state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      wait_q, wait_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             in_fetch, in_mem, in_wb, mem_wait, timeout, active;

    assign in_fetch = state_q == S_FETCH;
    assign in_mem   = state_q == S_MEM;
    assign in_wb    = state_q == S_WB;
    assign mem_wait = (in_fetch & ~imem_ready) | (in_mem & ~dmem_ready);
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == 32'(MEM_TIMEOUT - 1));
    assign active   = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);

    // next-state selection; a ready arriving on the last allowed wait cycle beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:   state_d = imem_ready ? S_DECODE : (timeout ? S_ERROR : S_FETCH);
            S_DECODE:  state_d = is_halt ? S_HALT : S_EXECUTE;
            S_EXECUTE: state_d = (is_load | is_store) ? S_MEM : S_WB;
            S_MEM:     state_d = dmem_ready ? S_WB : (timeout ? S_ERROR : S_MEM);
            S_WB:      state_d = run ? S_FETCH : S_IDLE;
            default:   state_d = state_q;
        endcase
    end

    // datapath next values: instruction latch, wait counter cleared outside the memory states, counters
    always_comb begin
        instr_d   = (in_fetch && imem_ready) ? imem_rdata : instr_q;
        wait_d    = (in_fetch || in_mem) ? (mem_wait ? wait_q + 32'd1 : wait_q) : 32'd0;
        cycle_d   = active ? cycle_q + CNT_W'(1) : cycle_q;
        instret_d = in_wb ? instret_q + CNT_W'(1) : instret_q;
    end

    // state registers with synchronous reset abandoning any outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= NOP;
            wait_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            wait_q    <= wait_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req      = in_fetch;
    assign imem_addr     = in_fetch ? pc : 32'd0;
    assign instr         = instr_q;
    assign dmem_req      = in_mem;
    assign dmem_we       = in_mem & is_store;
    assign pc_enable     = in_wb;
    assign rf_we         = in_wb & writes_rd & ~is_store;
    assign halted        = state_q == S_HALT;
    assign bus_error     = state_q == S_ERROR;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed bench with writeback scoreboard for core_sequencer
module tb_core_sequencer;
    localparam logic [31:0] K = 32'hA5A5_0013;

    typedef struct {
        logic [31:0] instr;
        logic        rf;
        logic        we;
        int          lat;
    } exp_t;

    logic        clk = 0;
    logic        reset, run;
    logic [31:0] pc;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata, instr;
    logic        is_load, is_store, is_halt, writes_rd;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        pc_enable, rf_we, halted, bus_error;
    logic [31:0] cycle_count, instret_count;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start = 0;
    int   icnt = 0;
    int   dcnt = 0;
    int   imem_lat, dmem_lat;
    logic req_prev = 0;
    exp_t sb[$];

    core_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .writes_rd(writes_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .pc_enable(pc_enable), .rf_we(rf_we), .halted(halted), .bus_error(bus_error),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        icnt <= imem_req ? icnt + 1 : 0;
        dcnt <= dmem_req ? dcnt + 1 : 0;
        pc   <= reset ? 32'd0 : (pc_enable ? pc + 32'd4 : pc);
    end

    assign imem_rdata = pc ^ K;
    assign imem_ready = imem_req && (icnt == imem_lat);
    assign dmem_ready = dmem_req && (dcnt == dmem_lat);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // writeback monitor: pops one expected retirement per pc_enable pulse
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            req_prev = 0;
        end else begin
            if (imem_req && !req_prev) start = cyc;
            req_prev = imem_req;
            if (dmem_req && sb.size() != 0) chk("dmem_we", dmem_we, sb[0].we);
            if (pc_enable) begin
                chk("wb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wb_instr", instr, e.instr);
                    chk("wb_rf_we", rf_we, e.rf);
                    chk("wb_latency", cyc - start + 1, e.lat);
                    chk("wb_no_mem_req", imem_req | dmem_req, 0);
                end
            end
        end
    end

    task automatic wait_pc(input int budget);
        int n = 0;
        while (!pc_enable && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wb_reached", pc_enable, 1);
    endtask

    task automatic do_instr(input logic ld, st, wr, input int il, dl, input logic exp_rf, input int exp_lat);
        is_load = ld; is_store = st; writes_rd = wr; is_halt = 0;
        imem_lat = il; dmem_lat = dl;
        sb.push_back('{pc ^ K, exp_rf, st, exp_lat});
        run = 1;
        @(negedge clk);
        run = 0;
        wait_pc(40);
        @(negedge clk);
        chk("idle_after_wb", imem_req | dmem_req | pc_enable, 0);
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; run = 0; is_load = 0; is_store = 0; is_halt = 0; writes_rd = 1;
        imem_lat = 0; dmem_lat = 0;
        repeat (3) @(negedge clk);
        chk("rst_reqs", {imem_req, dmem_req, dmem_we, pc_enable, rf_we, halted, bus_error}, 0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_addr", imem_addr, 0);
        chk("rst_counts", {cycle_count, instret_count}, 0);
        reset = 0;
        for (int i = 0; i < 3; i++) sb.push_back('{(32'(4 * i)) ^ K, 1'b1, 1'b0, 4});
        run = 1;
        @(negedge clk);
        chk("c1_fetch", imem_req, 1);
        repeat (3) @(negedge clk);
        chk("c4_wb", {pc_enable, rf_we, imem_req}, 3'b110);
        @(negedge clk);
        chk("c5_fetch", imem_req, 1);
        chk("c5_addr", imem_addr, 4);
        repeat (6) @(negedge clk);
        run = 0;
        repeat (2) @(negedge clk);
        chk("c13_idle", imem_req | pc_enable, 0);
        chk("c13_instret", instret_count, 3);
        chk("c13_cycles", cycle_count, 12);
        @(negedge clk);
        chk("c14_idle", imem_req, 0);
        is_load = 1; dmem_lat = 2;
        sb.push_back('{pc ^ K, 1'b1, 1'b0, 7});
        run = 1;
        @(negedge clk);
        chk("rerun_fetch", imem_req, 1);
        run = 0;
        repeat (3) @(negedge clk);
        chk("load_mem", {dmem_req, dmem_we}, 2'b10);
        wait_pc(10);
        @(negedge clk);
        do_instr(0, 1, 1, 0, 2, 0, 7);
        chk("instret_5", instret_count, 5);
        do_instr(0, 0, 1, 3, 0, 1, 7);
        chk("late_ready_no_err", bus_error, 0);
        chk("instret_6", instret_count, 6);
        imem_lat = 1000; is_load = 0; is_store = 0;
        run = 1;
        @(negedge clk);
        run = 0;
        repeat (3) @(negedge clk);
        chk("ito_c4", {imem_req, bus_error}, 2'b10);
        @(negedge clk);
        chk("ito_c5", {bus_error, imem_req, pc_enable}, 3'b100);
        run = 1;
        repeat (3) @(negedge clk);
        chk("ito_held", {bus_error, imem_req, dmem_req}, 3'b100);
        run = 0;
        pulse_reset();
        chk("err_cleared", {bus_error, cycle_count, instret_count}, 0);
        imem_lat = 0; is_load = 1; dmem_lat = 1000;
        run = 1;
        @(negedge clk);
        run = 0;
        repeat (6) @(negedge clk);
        chk("dto_c7", {dmem_req, bus_error}, 2'b10);
        @(negedge clk);
        chk("dto_c8", {bus_error, dmem_req, pc_enable}, 3'b100);
        chk("dto_cycles", cycle_count, 7);
        pulse_reset();
        is_load = 0; is_halt = 1;
        run = 1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("halt_flag", {halted, imem_req, pc_enable}, 3'b100);
        chk("halt_instret", instret_count, 0);
        chk("halt_cycles", cycle_count, 2);
        run = 0;
        @(negedge clk);
        run = 1;
        repeat (3) @(negedge clk);
        chk("halt_sticky", {halted, imem_req}, 2'b10);
        chk("halt_cycles_frozen", cycle_count, 2);
        run = 0;
        pulse_reset();
        is_halt = 0;
        chk("halt_cleared", halted, 0);
        is_load = 1; dmem_lat = 1000;
        run = 1;
        @(negedge clk);
        run = 0;
        repeat (3) @(negedge clk);
        chk("mid_mem_req", dmem_req, 1);
        reset = 1;
        @(negedge clk);
        chk("abort_outs", {imem_req, dmem_req, dmem_we, pc_enable, rf_we, halted, bus_error}, 0);
        chk("abort_instr", instr, 32'h0000_0013);
        chk("abort_counts", {cycle_count, instret_count}, 0);
        chk("abort_addr", imem_addr, 0);
        reset = 0;
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", imem_req | dmem_req | pc_enable, 0);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue RV32 core.
- Sequences each instruction through fetch, decode, execute, optional data-memory access and writeback.
- Issues the one-cycle enable pulse that advances the program counter exactly once per retired instruction.
- Handles instruction/data memory ready handshakes with timeout, halt on decoded ebreak/ecall, and keeps cycle/instret counters.

Parameters:
- MEM_TIMEOUT, 255: consecutive not-ready cycles in FETCH or MEM before a bus error; 0 disables the timeout.
- CNT_W, 32: width of the cycle and instret counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- run  in  1  start/continue execution; sampled in IDLE and WB
- pc  in  32  current PC from the program counter
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (equals pc while imem_req)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  instruction register, feeds the decoder
- is_load  in  1  decoder: load instruction
- is_store  in  1  decoder: store instruction
- is_halt  in  1  decoder: ebreak/ecall
- writes_rd  in  1  decoder: instruction writes rd
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write strobe (store)
- dmem_ready  in  1  data access complete this cycle
- pc_enable  out  1  PC advance pulse
- rf_we  out  1  register-file write pulse
- halted  out  1  sticky halt flag
- bus_error  out  1  sticky timeout flag
- cycle_count  out  CNT_W  active-cycle counter
- instret_count  out  CNT_W  retired-instruction counter

Behaviour:
- Reset (synchronous, clk is the only clock): state=IDLE, instr=0x00000013 (NOP), all counters 0, wait counter 0, all outputs 0. Reset mid-operation abandons any outstanding request with no further pulses.
- IDLE: no requests. If run=1, go to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1: load instr from imem_rdata, go to DECODE.
  - Ready in the first FETCH cycle means FETCH lasts 1 cycle.
- DECODE: decoder inputs are valid from the held instr.
  - is_halt=1: go to HALT; no pc_enable, no rf_we, no instret increment.
  - Otherwise go to EXECUTE.
- EXECUTE: single cycle for ALU/branch settling.
  - is_load or is_store: go to MEM.
  - Otherwise go to WB.
- MEM: dmem_req=1, dmem_we=is_store. On dmem_ready=1 go to WB.
- WB: exactly one cycle.
  - pc_enable=1.
  - rf_we = writes_rd & ~is_store.
  - instret_count += 1.
  - run=1: go to FETCH; run=0: go to IDLE.
- pc_enable and rf_we are asserted only in WB and are never asserted in the same cycle as any memory request.
- Timeout: wait counter clears on entering FETCH or MEM and increments each cycle the state's ready is 0.
  - Counter reaches MEM_TIMEOUT with ready still 0: go to ERROR next cycle.
  - Ready arriving in that same cycle wins.
  - MEM_TIMEOUT=0: never time out.
- HALT: halted=1, all requests 0; held until reset.
- ERROR: bus_error=1, all requests 0; held until reset.
- run deassert mid-instruction does not abort; the instruction completes through WB, then the FSM enters IDLE.
- cycle_count increments every cycle the state is not IDLE, HALT or ERROR.
- Both counters wrap modulo 2^CNT_W with no flag.
- Latency with zero-wait memory (ready in first request cycle):
  - ALU/branch: 4 cycles, FETCH-DECODE-EXECUTE-WB.
  - Load/store: 5 cycles.
- Each wait cycle adds 1.
- instr is stable from the DECODE cycle through WB.

Test Plan:
- Reset, run=1, imem_ready tied 1, ALU instr (addi, writes_rd=1) -> pc_enable and rf_we high in cycle 4 only; next imem_req in cycle 5; after 3 instructions instret_count=3, cycle_count=12.
- Load with dmem_ready delayed 2 cycles -> MEM lasts 3 cycles, dmem_we=0, rf_we=1 in WB. Store -> dmem_we=1, rf_we=0, pc_enable=1. Total 7 cycles each.
- MEM_TIMEOUT=4, imem_ready held 0 -> ERROR entered after 4 FETCH cycles, bus_error=1, imem_req=0, no pc_enable. Repeat with ready in the 4th wait cycle -> normal DECODE, no error.
- is_halt=1 on fetched instr -> halted=1 after DECODE, instret_count unchanged, no pc_enable; run toggling has no effect until reset.
- run dropped during EXECUTE -> WB completes with one pc_enable, then IDLE with no imem_req; run reasserted -> FETCH next cycle.
- reset asserted during MEM with dmem_req=1 -> next cycle all outputs 0, counters 0, state IDLE, no rf_we/pc_enable pulse.
